// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl bus bundle: core request/response side and data-memory side.
// slave = sequencer view, master = core + memory view.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              lsu_req_i;
  logic              lsu_we_i;
  logic [2:0]        lsu_size_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [31:0]       lsu_wdata_i;
  logic              lsu_stall_o;
  logic              lsu_valid_o;
  logic [31:0]       lsu_rdata_o;
  logic              lsu_err_o;
  logic              dm_req_o;
  logic              dm_we_o;
  logic [3:0]        dm_be_o;
  logic [ADDR_W-1:0] dm_addr_o;
  logic [31:0]       dm_wd_o;
  logic [31:0]       dm_rd_i;

  modport slave (
    input  lsu_req_i, lsu_we_i, lsu_size_i,
    input  lsu_addr_i, lsu_wdata_i,
    output lsu_stall_o, lsu_valid_o,
    output lsu_rdata_o, lsu_err_o,
    output dm_req_o, dm_we_o, dm_be_o,
    output dm_addr_o, dm_wd_o,
    input  dm_rd_i
  );

  modport master (
    output lsu_req_i, lsu_we_i, lsu_size_i,
    output lsu_addr_i, lsu_wdata_i,
    input  lsu_stall_o, lsu_valid_o,
    input  lsu_rdata_o, lsu_err_o,
    input  dm_req_o, dm_we_o, dm_be_o,
    input  dm_addr_o, dm_wd_o,
    output dm_rd_i
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: size decode, lane shifting,
// misaligned split into two word accesses, load extension.
module lsu_ctrl #(
  parameter bit MISALIGN_EN = 1'b1,
  parameter int ADDR_W      = 32
) (
  input logic       clk_i,
  input logic       rst_n_i,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC0,
    S_WAIT0,
    S_ACC1,
    S_WAIT1,
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_we;
  logic [2:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_split;
  logic [31:0]       r_lo;
  logic [31:0]       r_hi;
  logic [31:0]       r_rdata;

  logic [1:0]        w_in_off;
  logic              w_in_legal;
  logic              w_in_split;
  logic              w_bad;

  logic [1:0]        w_off;
  logic [3:0]        w_mask;
  logic [7:0]        w_be8;
  logic [63:0]       w_wd64;
  logic [63:0]       w_cat;
  logic [31:0]       w_raw;
  logic [31:0]       w_ext;
  logic              w_sgn;
  logic [ADDR_W-1:0] w_word0;
  logic [ADDR_W-1:0] w_word1;

  // Decode of the incoming request, used only while IDLE.
  assign w_in_off = bus.lsu_addr_i[1:0];

  always_comb begin
    w_in_legal = 1'b0;
    unique case (bus.lsu_size_i)
      3'b000, 3'b001, 3'b010,
      3'b100, 3'b101: w_in_legal = 1'b1;
      default:        w_in_legal = 1'b0;
    endcase
  end

  assign w_in_split =
    ((bus.lsu_size_i[1:0] == 2'b01) && (w_in_off == 2'd3)) ||
    ((bus.lsu_size_i[1:0] == 2'b10) && (w_in_off != 2'd0));

  assign w_bad = !w_in_legal || (w_in_split && !MISALIGN_EN);

  // Lane geometry of the latched access. The 8-bit enable and 64-bit
  // data views span both words: low half is word0, high half word1.
  assign w_off = r_addr[1:0];

  always_comb begin
    w_mask = 4'b1111;
    unique case (r_size[1:0])
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  assign w_be8   = {4'b0000, w_mask} << w_off;
  assign w_wd64  = {32'h0, r_wdata} << {w_off, 3'b000};
  assign w_word0 = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_word1 = w_word0 + ADDR_W'(4);

  // Reassemble the load word and extend by size.
  assign w_cat = {r_hi, r_lo} >> {w_off, 3'b000};
  assign w_raw = w_cat[31:0];
  assign w_sgn = !r_size[2];

  always_comb begin
    w_ext = w_raw;
    unique case (r_size[1:0])
      2'b00:   w_ext = {{24{w_sgn & w_raw[7]}}, w_raw[7:0]};
      2'b01:   w_ext = {{16{w_sgn & w_raw[15]}}, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Request latch, read-word capture and held response data.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_we    <= 1'b0;
      r_size  <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_split <= 1'b0;
      r_lo    <= 32'h0;
      r_hi    <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      if (r_state == S_IDLE && bus.lsu_req_i) begin
        r_we    <= bus.lsu_we_i;
        r_size  <= bus.lsu_size_i;
        r_addr  <= bus.lsu_addr_i;
        r_wdata <= bus.lsu_wdata_i;
        r_split <= w_in_split;
        r_lo    <= 32'h0;
        r_hi    <= 32'h0;
      end
      if (r_state == S_WAIT0) r_lo <= bus.dm_rd_i;
      if (r_state == S_WAIT1) r_hi <= bus.dm_rd_i;
      if (r_state == S_DONE)  r_rdata <= w_ext;
      if (r_state == S_ERR)   r_rdata <= 32'h0;
    end
  end

  // Next state and all bus outputs.
  always_comb begin
    w_next          = r_state;
    bus.lsu_stall_o = 1'b0;
    bus.lsu_valid_o = 1'b0;
    bus.lsu_err_o   = 1'b0;
    bus.lsu_rdata_o = r_rdata;
    bus.dm_req_o    = 1'b0;
    bus.dm_we_o     = 1'b0;
    bus.dm_be_o     = 4'b0000;
    bus.dm_addr_o   = '0;
    bus.dm_wd_o     = 32'h0;
    unique case (r_state)
      S_IDLE: begin
        bus.lsu_stall_o = bus.lsu_req_i;
        if (bus.lsu_req_i) w_next = w_bad ? S_ERR : S_ACC0;
      end
      S_ACC0: begin
        bus.lsu_stall_o = 1'b1;
        bus.dm_req_o    = 1'b1;
        bus.dm_we_o     = r_we;
        bus.dm_be_o     = w_be8[3:0];
        bus.dm_addr_o   = w_word0;
        bus.dm_wd_o     = w_wd64[31:0];
        if (!r_we)        w_next = S_WAIT0;
        else if (r_split) w_next = S_ACC1;
        else              w_next = S_DONE;
      end
      S_WAIT0: begin
        bus.lsu_stall_o = 1'b1;
        w_next = r_split ? S_ACC1 : S_DONE;
      end
      S_ACC1: begin
        bus.lsu_stall_o = 1'b1;
        bus.dm_req_o    = 1'b1;
        bus.dm_we_o     = r_we;
        bus.dm_be_o     = w_be8[7:4];
        bus.dm_addr_o   = w_word1;
        bus.dm_wd_o     = w_wd64[63:32];
        w_next = r_we ? S_DONE : S_WAIT1;
      end
      S_WAIT1: begin
        bus.lsu_stall_o = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        bus.lsu_valid_o = 1'b1;
        bus.lsu_rdata_o = w_ext;
        w_next = S_IDLE;
      end
      S_ERR: begin
        bus.lsu_valid_o = 1'b1;
        bus.lsu_err_o   = 1'b1;
        bus.lsu_rdata_o = 32'h0;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed cases plus random loads/stores
// against a byte-level memory reference model.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_W(32)) bus1 ();
  lsu_ctrl_if #(.ADDR_W(32)) bus2 ();

  lsu_ctrl #(.MISALIGN_EN(1'b1), .ADDR_W(32)) u_dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus1.slave)
  );

  lsu_ctrl #(.MISALIGN_EN(1'b0), .ADDR_W(32)) u_dut_na (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus2.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  // Memory seen by the DUT (word array) and the reference (byte array).
  logic [31:0] mem_w [logic [31:0]];
  logic [7:0]  ref_b [logic [31:0]];

  logic [31:0] rec_addr [$];
  logic [3:0]  rec_be [$];
  logic [31:0] rec_wd [$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_w.exists(a) ? mem_w[a] : 32'h0;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_b.exists(a) ? ref_b[a] : 8'h0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
    return v;
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] w);
    mem_w[wa] = w;
    for (int i = 0; i < 4; i++) ref_b[wa + 32'(i)] = w[8*i +: 8];
  endtask

  function automatic int sz_bytes(input logic [2:0] s);
    case (s)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Drive one request on bus1 and act as the data memory until the
  // completion pulse, then step into the following idle cycle.
  task automatic access(input logic we, input logic [2:0] size,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output logic err, output logic ok);
    logic [31:0] a;
    logic [31:0] w;
    rec_addr.delete();
    rec_be.delete();
    rec_wd.delete();
    lat = 0;
    rd  = 32'h0;
    err = 1'b0;
    ok  = 1'b1;
    bus1.lsu_req_i   = 1'b1;
    bus1.lsu_we_i    = we;
    bus1.lsu_size_i  = size;
    bus1.lsu_addr_i  = addr;
    bus1.lsu_wdata_i = wd;
    #1;
    if (bus1.lsu_stall_o !== 1'b1) ok = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (bus1.dm_req_o === 1'b1) begin
        a = bus1.dm_addr_o;
        if (a[1:0] != 2'b00) ok = 1'b0;
        if (bus1.dm_we_o !== we) ok = 1'b0;
        rec_addr.push_back(a);
        rec_be.push_back(bus1.dm_be_o);
        rec_wd.push_back(bus1.dm_wd_o);
        if (bus1.dm_we_o === 1'b1) begin
          w = mem_rd(a);
          for (int b = 0; b < 4; b++)
            if (bus1.dm_be_o[b]) w[8*b +: 8] = bus1.dm_wd_o[8*b +: 8];
          mem_w[a] = w;
        end else begin
          bus1.dm_rd_i = mem_rd(a);
        end
      end
      if (bus1.lsu_valid_o === 1'b1) begin
        lat = k;
        rd  = bus1.lsu_rdata_o;
        err = bus1.lsu_err_o;
        if (bus1.lsu_stall_o !== 1'b0) ok = 1'b0;
        break;
      end else if (bus1.lsu_stall_o !== 1'b1) begin
        ok = 1'b0;
      end
    end
    bus1.lsu_req_i = 1'b0;
    @(posedge clk);
    #1;
    if (bus1.lsu_stall_o !== 1'b0 || bus1.dm_req_o !== 1'b0) ok = 1'b0;
  endtask

  // Run one operation and check it against the reference model.
  task automatic run_op(input string tag, input logic we,
                        input logic [2:0] size,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        output logic [31:0] rd_o);
    int          n;
    int          e_lat;
    bit          e_err;
    bit          e_split;
    logic [31:0] e_rd;
    int          lat;
    logic        err;
    logic        ok;
    n       = sz_bytes(size);
    e_err   = (n == 0);
    e_split = (n > 1) && (int'(addr[1:0]) + n > 4);
    if (e_err)   e_lat = 1;
    else if (we) e_lat = e_split ? 3 : 2;
    else         e_lat = e_split ? 5 : 3;
    e_rd = 32'h0;
    if (!e_err && !we) begin
      for (int i = 0; i < n; i++) e_rd[8*i +: 8] = ref_rd(addr + 32'(i));
      if (size == 3'b000 && e_rd[7])  e_rd[31:8]  = 24'hFFFFFF;
      if (size == 3'b001 && e_rd[15]) e_rd[31:16] = 16'hFFFF;
    end
    access(we, size, addr, wd, lat, rd_o, err, ok);
    chk({tag, ".lat"}, lat, e_lat);
    chk({tag, ".err"}, {31'h0, err}, {31'h0, e_err});
    chk({tag, ".bus"}, {31'h0, ok}, 32'h1);
    if (e_err) begin
      chk({tag, ".rd0"}, rd_o, 32'h0);
      chk({tag, ".nacc"}, rec_addr.size(), 0);
    end else if (!we) begin
      chk({tag, ".rd"}, rd_o, e_rd);
    end else begin
      for (int i = 0; i < n; i++) ref_b[addr + 32'(i)] = wd[8*i +: 8];
      chk({tag, ".mem0"}, mem_rd(addr & ~32'h3),
          ref_word(addr & ~32'h3));
      chk({tag, ".mem1"}, mem_rd((addr + 32'(n - 1)) & ~32'h3),
          ref_word((addr + 32'(n - 1)) & ~32'h3));
    end
  endtask

  logic [31:0] rd;
  logic        r_we;
  logic [2:0]  r_sz;
  logic [31:0] r_ad;

  initial begin
    bus1.lsu_req_i   = 1'b0;
    bus1.lsu_we_i    = 1'b0;
    bus1.lsu_size_i  = 3'b000;
    bus1.lsu_addr_i  = 32'h0;
    bus1.lsu_wdata_i = 32'h0;
    bus1.dm_rd_i     = 32'h0;
    bus2.lsu_req_i   = 1'b0;
    bus2.lsu_we_i    = 1'b0;
    bus2.lsu_size_i  = 3'b000;
    bus2.lsu_addr_i  = 32'h0;
    bus2.lsu_wdata_i = 32'h0;
    bus2.dm_rd_i     = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.req",   {31'h0, bus1.dm_req_o}, 32'h0);
    chk("rst.valid", {31'h0, bus1.lsu_valid_o}, 32'h0);
    chk("rst.stall", {31'h0, bus1.lsu_stall_o}, 32'h0);
    chk("rst.rdata", bus1.lsu_rdata_o, 32'h0);
    chk("rst.be",    {28'h0, bus1.dm_be_o}, 32'h0);
    chk("rst.addr",  bus1.dm_addr_o, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset while a load sits in WAIT0.
    preload(32'h8, 32'hDEADBEEF);
    bus1.lsu_req_i  = 1'b1;
    bus1.lsu_we_i   = 1'b0;
    bus1.lsu_size_i = 3'b010;
    bus1.lsu_addr_i = 32'h8;
    @(posedge clk);
    #1;
    chk("mid.acc0", {31'h0, bus1.dm_req_o}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus1.lsu_req_i = 1'b0;
    @(posedge clk);
    #1;
    chk("mid.req",   {31'h0, bus1.dm_req_o}, 32'h0);
    chk("mid.valid", {31'h0, bus1.lsu_valid_o}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid.idle", {31'h0, bus1.lsu_stall_o | bus1.dm_req_o |
                            bus1.lsu_valid_o}, 32'h0);

    // Aligned LW.
    run_op("lw", 1'b0, 3'b010, 32'h8, 32'h0, rd);
    chk("lw.rdc", rd, 32'hDEADBEEF);
    chk("lw.addr", rec_addr[0], 32'h8);
    chk("lw.be", {28'h0, rec_be[0]}, 32'hF);

    // Sign / zero extension.
    preload(32'h4, 32'h00008000);
    run_op("lb", 1'b0, 3'b000, 32'h5, 32'h0, rd);
    chk("lb.rdc", rd, 32'hFFFFFF80);
    run_op("lbu", 1'b0, 3'b100, 32'h5, 32'h0, rd);
    chk("lbu.rdc", rd, 32'h00000080);
    preload(32'h0, 32'h80010000);
    run_op("lh", 1'b0, 3'b001, 32'h2, 32'h0, rd);
    chk("lh.rdc", rd, 32'hFFFF8001);

    // Misaligned SW.
    run_op("sw", 1'b1, 3'b010, 32'hE, 32'h11223344, rd);
    chk("sw.n", rec_addr.size(), 2);
    chk("sw.a0", rec_addr[0], 32'hC);
    chk("sw.be0", {28'h0, rec_be[0]}, 32'hC);
    chk("sw.wd0", rec_wd[0], 32'h33440000);
    chk("sw.a1", rec_addr[1], 32'h10);
    chk("sw.be1", {28'h0, rec_be[1]}, 32'h3);
    chk("sw.wd1", rec_wd[1], 32'h00001122);

    // Misaligned LH.
    preload(32'h0, 32'hAA000000);
    preload(32'h4, 32'h000000BB);
    run_op("mlh", 1'b0, 3'b001, 32'h3, 32'h0, rd);
    chk("mlh.rdc", rd, 32'hFFFFBBAA);
    chk("mlh.be0", {28'h0, rec_be[0]}, 32'h8);
    chk("mlh.be1", {28'h0, rec_be[1]}, 32'h1);

    // Illegal size.
    run_op("ill", 1'b0, 3'b011, 32'h4, 32'h0, rd);

    // Word wrap at the top of the address space.
    preload(32'hFFFFFFFC, 32'h44332211);
    preload(32'h0, 32'h88776655);
    run_op("wrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, rd);
    chk("wrap.rdc", rd, 32'h66554433);
    chk("wrap.a0", rec_addr[0], 32'hFFFFFFFC);
    chk("wrap.a1", rec_addr[1], 32'h0);

    // Misalign disabled: error, no memory access.
    bus2.lsu_req_i  = 1'b1;
    bus2.lsu_we_i   = 1'b0;
    bus2.lsu_size_i = 3'b010;
    bus2.lsu_addr_i = 32'h1;
    #1;
    chk("na.stall", {31'h0, bus2.lsu_stall_o}, 32'h1);
    @(posedge clk);
    #1;
    chk("na.valid", {31'h0, bus2.lsu_valid_o}, 32'h1);
    chk("na.err",   {31'h0, bus2.lsu_err_o}, 32'h1);
    chk("na.rdata", bus2.lsu_rdata_o, 32'h0);
    chk("na.req",   {31'h0, bus2.dm_req_o}, 32'h0);
    bus2.lsu_req_i = 1'b0;
    @(posedge clk);
    #1;
    chk("na.idle", {31'h0, bus2.lsu_valid_o | bus2.dm_req_o}, 32'h0);

    // Random traffic over a small window.
    for (int w = 0; w < 16; w++) preload(32'(4 * w), $urandom);
    for (int t = 0; t < 120; t++) begin
      r_we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 15))
        0:       r_sz = 3'b011;
        1, 2:    r_sz = r_we ? 3'b000 : 3'b100;
        3, 4:    r_sz = r_we ? 3'b001 : 3'b101;
        5, 6, 7: r_sz = 3'b000;
        8, 9:    r_sz = 3'b001;
        default: r_sz = 3'b010;
      endcase
      r_ad = 32'($urandom_range(0, 59));
      run_op("rnd", r_we, r_sz, r_ad, $urandom, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
